// File: rtl/lsu_issue_queue_if.sv
// Dispatch, CDB, flush and issue signals of the LSU issue queue.
// The slave modport is the queue. The master modport is its environment.
interface lsu_issue_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int PREG_WIDTH = 7,
  parameter int DEPTH      = 8
);
  logic                    i_flush;
  logic                    i_disp_valid;
  logic                    o_disp_ready;
  logic                    i_disp_memwrite;
  logic [DATA_WIDTH-1:0]   i_disp_imm;
  logic [PREG_WIDTH-1:0]   i_disp_prs1;
  logic                    i_disp_rs1_rdy;
  logic [DATA_WIDTH-1:0]   i_disp_rs1_val;
  logic [PREG_WIDTH-1:0]   i_disp_prs2;
  logic                    i_disp_rs2_rdy;
  logic [DATA_WIDTH-1:0]   i_disp_rs2_val;
  logic [PREG_WIDTH-1:0]   i_disp_prd;
  logic [ROB_WIDTH-1:0]    i_disp_rob_tag;
  logic                    i_cdb_valid;
  logic [PREG_WIDTH-1:0]   i_cdb_prd;
  logic [DATA_WIDTH-1:0]   i_cdb_data;
  logic                    o_valid;
  logic                    i_lsu_ready;
  logic [DATA_WIDTH-1:0]   o_base_addr;
  logic [DATA_WIDTH-1:0]   o_offset;
  logic [DATA_WIDTH-1:0]   o_store_data;
  logic                    o_memwrite;
  logic [PREG_WIDTH-1:0]   o_prd;
  logic [ROB_WIDTH-1:0]    o_rob_tag;
  logic [$clog2(DEPTH):0]  o_count;

  modport master (
    output i_flush, i_disp_valid, i_disp_memwrite, i_disp_imm, i_disp_prs1,
           i_disp_rs1_rdy, i_disp_rs1_val, i_disp_prs2, i_disp_rs2_rdy,
           i_disp_rs2_val, i_disp_prd, i_disp_rob_tag, i_cdb_valid, i_cdb_prd,
           i_cdb_data, i_lsu_ready,
    input  o_disp_ready, o_valid, o_base_addr, o_offset, o_store_data,
           o_memwrite, o_prd, o_rob_tag, o_count
  );

  modport slave (
    input  i_flush, i_disp_valid, i_disp_memwrite, i_disp_imm, i_disp_prs1,
           i_disp_rs1_rdy, i_disp_rs1_val, i_disp_prs2, i_disp_rs2_rdy,
           i_disp_rs2_val, i_disp_prd, i_disp_rob_tag, i_cdb_valid, i_cdb_prd,
           i_cdb_data, i_lsu_ready,
    output o_disp_ready, o_valid, o_base_addr, o_offset, o_store_data,
           o_memwrite, o_prd, o_rob_tag, o_count
  );
endinterface

// File: rtl/lsu_issue_queue.sv
// In-order load/store issue queue that captures missing operands from the CDB and issues only the head entry.
// Optional macro LSU_IQ_STORE_COMMIT_EN holds stores at the head until their ROB tag has committed.
module lsu_issue_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int PREG_WIDTH = 7,
  parameter int DEPTH      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef LSU_IQ_STORE_COMMIT_EN
  input  logic                 i_commit_valid,
  input  logic [ROB_WIDTH-1:0] i_commit_rob_tag,
`endif
  lsu_issue_queue_if.slave     q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      head, tail;
  logic [CNT_W-1:0]      count;
  logic [DEPTH-1:0]      ent_valid, ent_memwrite, ent_rs1_rdy, ent_rs2_rdy;
  logic [DATA_WIDTH-1:0] ent_imm [DEPTH];
  logic [DATA_WIDTH-1:0] ent_rs1_val [DEPTH];
  logic [DATA_WIDTH-1:0] ent_rs2_val [DEPTH];
  logic [PREG_WIDTH-1:0] ent_prs1 [DEPTH];
  logic [PREG_WIDTH-1:0] ent_prs2 [DEPTH];
  logic [PREG_WIDTH-1:0] ent_prd [DEPTH];
  logic [ROB_WIDTH-1:0]  ent_rob [DEPTH];

  logic not_empty, push, fire, cdb_live, head_ops_rdy, head_commit_ok;
  logic disp_rs1_hit, disp_rs2_hit;

  // Tag 0 is the hardwired zero register and never appears on the CDB as a real producer.
  assign cdb_live     = q.i_cdb_valid && (q.i_cdb_prd != '0);
  assign disp_rs1_hit = !q.i_disp_rs1_rdy && cdb_live && (q.i_cdb_prd == q.i_disp_prs1);
  assign disp_rs2_hit = !q.i_disp_rs2_rdy && cdb_live && (q.i_cdb_prd == q.i_disp_prs2);

  assign not_empty      = (count != '0);
  assign q.o_disp_ready = (count < CNT_W'(DEPTH));
  assign push           = q.i_disp_valid && q.o_disp_ready;
  assign fire           = q.o_valid && q.i_lsu_ready;
  assign head_ops_rdy   = ent_rs1_rdy[head] && (!ent_memwrite[head] || ent_rs2_rdy[head]);

`ifdef LSU_IQ_STORE_COMMIT_EN
  logic [DEPTH-1:0] ent_committed;

  assign head_commit_ok = !ent_memwrite[head] || ent_committed[head] ||
                          (i_commit_valid && (i_commit_rob_tag == ent_rob[head]));

  // A commit can arrive before the store reaches the head, so it is remembered per entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_committed <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[i] && ent_memwrite[i] && i_commit_valid && (i_commit_rob_tag == ent_rob[i]))
          ent_committed[i] <= 1'b1;
      end
      if (push)
        ent_committed[tail] <= 1'b0;
    end
  end
`else
  assign head_commit_ok = 1'b1;
`endif

  assign q.o_valid      = not_empty && head_ops_rdy && head_commit_ok;
  assign q.o_base_addr  = not_empty ? ent_rs1_val[head] : '0;
  assign q.o_offset     = not_empty ? ent_imm[head] : '0;
  assign q.o_store_data = not_empty ? ent_rs2_val[head] : '0;
  assign q.o_memwrite   = not_empty ? ent_memwrite[head] : 1'b0;
  assign q.o_prd        = not_empty ? ent_prd[head] : '0;
  assign q.o_rob_tag    = not_empty ? ent_rob[head] : '0;
  assign q.o_count      = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      ent_valid    <= '0;
      ent_memwrite <= '0;
      ent_rs1_rdy  <= '0;
      ent_rs2_rdy  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_imm[i]     <= '0;
        ent_rs1_val[i] <= '0;
        ent_rs2_val[i] <= '0;
        ent_prs1[i]    <= '0;
        ent_prs2[i]    <= '0;
        ent_prd[i]     <= '0;
        ent_rob[i]     <= '0;
      end
    end else if (q.i_flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[i] && cdb_live) begin
          if (!ent_rs1_rdy[i] && (ent_prs1[i] == q.i_cdb_prd)) begin
            ent_rs1_rdy[i] <= 1'b1;
            ent_rs1_val[i] <= q.i_cdb_data;
          end
          if (!ent_rs2_rdy[i] && (ent_prs2[i] == q.i_cdb_prd)) begin
            ent_rs2_rdy[i] <= 1'b1;
            ent_rs2_val[i] <= q.i_cdb_data;
          end
        end
      end
      if (fire) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      // The tail slot is never the popping head here, since a push needs a non-full queue.
      if (push) begin
        ent_valid[tail]    <= 1'b1;
        ent_memwrite[tail] <= q.i_disp_memwrite;
        ent_imm[tail]      <= q.i_disp_imm;
        ent_prs1[tail]     <= q.i_disp_prs1;
        ent_prs2[tail]     <= q.i_disp_prs2;
        ent_prd[tail]      <= q.i_disp_prd;
        ent_rob[tail]      <= q.i_disp_rob_tag;
        ent_rs1_rdy[tail]  <= q.i_disp_rs1_rdy || disp_rs1_hit;
        ent_rs1_val[tail]  <= disp_rs1_hit ? q.i_cdb_data : q.i_disp_rs1_val;
        ent_rs2_rdy[tail]  <= !q.i_disp_memwrite || q.i_disp_rs2_rdy || disp_rs2_hit;
        ent_rs2_val[tail]  <= disp_rs2_hit ? q.i_cdb_data : q.i_disp_rs2_val;
        tail               <= tail + 1'b1;
      end
      case ({push, fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_issue_queue.sv
// Self-checking bench for lsu_issue_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_lsu_issue_queue;
  localparam int DW = 32, RW = 4, PW = 7, DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lsu_issue_queue_if #(.DATA_WIDTH(DW), .ROB_WIDTH(RW), .PREG_WIDTH(PW), .DEPTH(DEPTH)) iq ();

`ifdef LSU_IQ_STORE_COMMIT_EN
  logic          commit_valid;
  logic [RW-1:0] commit_tag;
  assign commit_valid = 1'b1;
  assign commit_tag   = iq.o_rob_tag;
`endif

  lsu_issue_queue #(.DATA_WIDTH(DW), .ROB_WIDTH(RW), .PREG_WIDTH(PW), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
`ifdef LSU_IQ_STORE_COMMIT_EN
    .i_commit_valid   (commit_valid),
    .i_commit_rob_tag (commit_tag),
`endif
    .q                (iq)
  );

  typedef struct {
    bit          mw;
    bit [DW-1:0] imm;
    bit [PW-1:0] prs1;
    bit          r1;
    bit [DW-1:0] v1;
    bit [PW-1:0] prs2;
    bit          r2;
    bit [DW-1:0] v2;
    bit [PW-1:0] prd;
    bit [RW-1:0] rob;
  } ent_t;

  ent_t mq[$];
  int   tests = 0;
  int   failed = 0;

  function automatic bit m_valid();
    if (mq.size() == 0) return 1'b0;
    return mq[0].r1 && (!mq[0].mw || mq[0].r2);
  endfunction

  task automatic idle();
    iq.i_flush = 0; iq.i_disp_valid = 0; iq.i_disp_memwrite = 0; iq.i_disp_imm = '0;
    iq.i_disp_prs1 = '0; iq.i_disp_rs1_rdy = 0; iq.i_disp_rs1_val = '0;
    iq.i_disp_prs2 = '0; iq.i_disp_rs2_rdy = 0; iq.i_disp_rs2_val = '0;
    iq.i_disp_prd = '0; iq.i_disp_rob_tag = '0;
    iq.i_cdb_valid = 0; iq.i_cdb_prd = '0; iq.i_cdb_data = '0;
  endtask

  task automatic set_disp(input bit mw, input bit [DW-1:0] imm, input bit [PW-1:0] prs1,
                          input bit r1, input bit [DW-1:0] v1, input bit [PW-1:0] prs2,
                          input bit r2, input bit [DW-1:0] v2, input bit [PW-1:0] prd,
                          input bit [RW-1:0] rob);
    iq.i_disp_valid = 1; iq.i_disp_memwrite = mw; iq.i_disp_imm = imm;
    iq.i_disp_prs1 = prs1; iq.i_disp_rs1_rdy = r1; iq.i_disp_rs1_val = v1;
    iq.i_disp_prs2 = prs2; iq.i_disp_rs2_rdy = r2; iq.i_disp_rs2_val = v2;
    iq.i_disp_prd = prd; iq.i_disp_rob_tag = rob;
  endtask

  // Advances the reference model by one cycle using the current inputs, then clocks the DUT.
  task automatic step();
    ent_t e, w;
    bit   fire, push, cdb;
    fire = m_valid() && iq.i_lsu_ready;
    push = iq.i_disp_valid && (mq.size() < DEPTH);
    cdb  = iq.i_cdb_valid && (iq.i_cdb_prd != 0);
    if (iq.i_flush) begin
      mq.delete();
    end else begin
      if (cdb) begin
        foreach (mq[i]) begin
          w = mq[i];
          if (!w.r1 && w.prs1 == iq.i_cdb_prd) begin w.r1 = 1; w.v1 = iq.i_cdb_data; end
          if (!w.r2 && w.prs2 == iq.i_cdb_prd) begin w.r2 = 1; w.v2 = iq.i_cdb_data; end
          mq[i] = w;
        end
      end
      if (fire) void'(mq.pop_front());
      if (push) begin
        e.mw = iq.i_disp_memwrite; e.imm = iq.i_disp_imm; e.prd = iq.i_disp_prd;
        e.rob = iq.i_disp_rob_tag; e.prs1 = iq.i_disp_prs1; e.prs2 = iq.i_disp_prs2;
        e.r1 = iq.i_disp_rs1_rdy; e.v1 = iq.i_disp_rs1_val;
        e.r2 = iq.i_disp_rs2_rdy; e.v2 = iq.i_disp_rs2_val;
        if (!e.r1 && cdb && iq.i_cdb_prd == e.prs1) begin e.r1 = 1; e.v1 = iq.i_cdb_data; end
        if (!e.r2 && cdb && iq.i_cdb_prd == e.prs2) begin e.r2 = 1; e.v2 = iq.i_cdb_data; end
        if (!e.mw) e.r2 = 1;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    iq.i_lsu_ready = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    tests++;
    if ({iq.o_valid, iq.o_disp_ready, iq.o_count, iq.o_base_addr, iq.o_offset, iq.o_store_data,
         iq.o_memwrite, iq.o_prd, iq.o_rob_tag} !== {1'b1 ^ 1'b1, 1'b1, 4'd0, 96'd0, 1'b0, 7'd0, 4'd0}) begin
      failed++;
      $display("[TB] FAIL reset_state: valid=%b ready=%b count=%0d base=%h prd=%0d, required valid=0 ready=1 count=0 all data 0",
               iq.o_valid, iq.o_disp_ready, iq.o_count, iq.o_base_addr, iq.o_prd);
    end
    set_disp(0, 32'h4, 7'd0, 1, 32'h80, 7'd0, 1, 32'h0, 7'd1, 4'd1);
    step();
    step();
    idle();
    tests++;
    if (iq.o_count !== 4'd2) begin
      failed++;
      $display("[TB] FAIL reset_prefill_count: got %0d, required 2", iq.o_count);
    end
    @(negedge clk);
    reset = 1;
    #1;
    tests++;
    if ({iq.o_count, iq.o_valid} !== {4'd0, 1'b0}) begin
      failed++;
      $display("[TB] FAIL async_reset: count=%0d valid=%b, required count=0 valid=0", iq.o_count, iq.o_valid);
    end
    mq.delete();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic test_load_issue();
    idle();
    iq.i_lsu_ready = 1;
    set_disp(0, 32'h8, 7'd0, 1, 32'h100, 7'd0, 1, 32'h0, 7'd5, 4'd3);
    step();
    idle();
    tests++;
    if ({iq.o_valid, iq.o_base_addr, iq.o_offset, iq.o_memwrite, iq.o_prd, iq.o_rob_tag}
        !== {1'b1, 32'h100, 32'h8, 1'b0, 7'd5, 4'd3}) begin
      failed++;
      $display("[TB] FAIL load_issue: valid=%b base=%h off=%h mw=%b prd=%0d rob=%0d, required 1 100 8 0 5 3",
               iq.o_valid, iq.o_base_addr, iq.o_offset, iq.o_memwrite, iq.o_prd, iq.o_rob_tag);
    end
    step();
    tests++;
    if ({iq.o_count, iq.o_valid} !== {4'd0, 1'b0}) begin
      failed++;
      $display("[TB] FAIL load_drain: count=%0d valid=%b, required 0 0", iq.o_count, iq.o_valid);
    end
  endtask

  task automatic test_store_wakeup();
    idle();
    iq.i_lsu_ready = 0;
    set_disp(1, 32'h10, 7'd3, 1, 32'h200, 7'd9, 0, 32'h0, 7'd0, 4'd4);
    step();
    idle();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (iq.o_valid !== 1'b0) begin
        failed++;
        $display("[TB] FAIL store_wait cycle %0d: valid=%b, required 0", k, iq.o_valid);
      end
      if (k == 1) begin
        iq.i_cdb_valid = 1; iq.i_cdb_prd = 7'd9; iq.i_cdb_data = 32'hDEAD;
      end
      step();
    end
    idle();
    tests++;
    if ({iq.o_valid, iq.o_memwrite, iq.o_store_data, iq.o_base_addr, iq.o_offset}
        !== {1'b1, 1'b1, 32'hDEAD, 32'h200, 32'h10}) begin
      failed++;
      $display("[TB] FAIL store_wakeup: valid=%b mw=%b sdata=%h base=%h, required 1 1 dead 200",
               iq.o_valid, iq.o_memwrite, iq.o_store_data, iq.o_base_addr);
    end
    iq.i_lsu_ready = 1;
    step();
    tests++;
    if (iq.o_count !== 4'd0) begin
      failed++;
      $display("[TB] FAIL store_drain: count=%0d, required 0", iq.o_count);
    end
  endtask

  task automatic test_head_blocking();
    idle();
    iq.i_lsu_ready = 1;
    set_disp(0, 32'h0, 7'd12, 0, 32'h0, 7'd0, 1, 32'h0, 7'd21, 4'd1);
    step();
    set_disp(0, 32'h4, 7'd0, 1, 32'h300, 7'd0, 1, 32'h0, 7'd22, 4'd2);
    step();
    idle();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({iq.o_valid, iq.o_count} !== {1'b0, 4'd2}) begin
        failed++;
        $display("[TB] FAIL head_block cycle %0d: valid=%b count=%0d, required 0 2", k, iq.o_valid, iq.o_count);
      end
      if (k == 1) begin
        iq.i_cdb_valid = 1; iq.i_cdb_prd = 7'd12; iq.i_cdb_data = 32'h400;
      end
      step();
    end
    idle();
    tests++;
    if ({iq.o_valid, iq.o_base_addr, iq.o_prd} !== {1'b1, 32'h400, 7'd21}) begin
      failed++;
      $display("[TB] FAIL order_first: valid=%b base=%h prd=%0d, required 1 400 21", iq.o_valid, iq.o_base_addr, iq.o_prd);
    end
    step();
    tests++;
    if ({iq.o_valid, iq.o_base_addr, iq.o_prd} !== {1'b1, 32'h300, 7'd22}) begin
      failed++;
      $display("[TB] FAIL order_second: valid=%b base=%h prd=%0d, required 1 300 22", iq.o_valid, iq.o_base_addr, iq.o_prd);
    end
    step();
    tests++;
    if (iq.o_count !== 4'd0) begin
      failed++;
      $display("[TB] FAIL order_drain: count=%0d, required 0", iq.o_count);
    end
  endtask

  task automatic test_full_wrap();
    bit [PW-1:0] exp_prd;
    idle();
    iq.i_lsu_ready = 0;
    for (int k = 0; k < DEPTH; k++) begin
      set_disp(0, 32'h1000 + k, 7'd0, 1, 32'h10 * k, 7'd0, 1, 32'h0, PW'(k + 1), RW'(k));
      step();
    end
    idle();
    tests++;
    if ({iq.o_disp_ready, iq.o_count, iq.o_prd} !== {1'b0, 4'd8, 7'd1}) begin
      failed++;
      $display("[TB] FAIL full: ready=%b count=%0d prd=%0d, required 0 8 1", iq.o_disp_ready, iq.o_count, iq.o_prd);
    end
    set_disp(0, 32'h0, 7'd0, 1, 32'h0, 7'd0, 1, 32'h0, 7'd20, 4'd0);
    step();
    idle();
    tests++;
    if (iq.o_count !== 4'd8) begin
      failed++;
      $display("[TB] FAIL overflow_drop: count=%0d, required 8", iq.o_count);
    end
    iq.i_lsu_ready = 1;
    step();
    iq.i_lsu_ready = 0;
    tests++;
    if ({iq.o_count, iq.o_prd} !== {4'd7, 7'd2}) begin
      failed++;
      $display("[TB] FAIL pop_one: count=%0d prd=%0d, required 7 2", iq.o_count, iq.o_prd);
    end
    set_disp(0, 32'h0, 7'd0, 1, 32'h0, 7'd0, 1, 32'h0, 7'd30, 4'd9);
    step();
    idle();
    iq.i_lsu_ready = 1;
    for (int k = 0; k < DEPTH; k++) begin
      exp_prd = (k < DEPTH - 1) ? PW'(k + 2) : 7'd30;
      tests++;
      if ({iq.o_valid, iq.o_prd} !== {1'b1, exp_prd}) begin
        failed++;
        $display("[TB] FAIL wrap_order %0d: valid=%b prd=%0d, required 1 %0d", k, iq.o_valid, iq.o_prd, exp_prd);
      end
      step();
    end
    tests++;
    if (iq.o_count !== 4'd0) begin
      failed++;
      $display("[TB] FAIL wrap_drain: count=%0d, required 0", iq.o_count);
    end
  endtask

  task automatic test_backpressure();
    idle();
    iq.i_lsu_ready = 0;
    set_disp(0, 32'h24, 7'd0, 1, 32'h500, 7'd0, 1, 32'h0, 7'd11, 4'd7);
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({iq.o_valid, iq.o_base_addr, iq.o_offset, iq.o_prd, iq.o_count}
          !== {1'b1, 32'h500, 32'h24, 7'd11, 4'd1}) begin
        failed++;
        $display("[TB] FAIL stall %0d: valid=%b base=%h prd=%0d count=%0d, required 1 500 11 1",
                 k, iq.o_valid, iq.o_base_addr, iq.o_prd, iq.o_count);
      end
      step();
    end
    iq.i_lsu_ready = 1;
    step();
    tests++;
    if ({iq.o_valid, iq.o_count} !== {1'b0, 4'd0}) begin
      failed++;
      $display("[TB] FAIL stall_release: valid=%b count=%0d, required 0 0", iq.o_valid, iq.o_count);
    end
  endtask

  task automatic test_flush();
    idle();
    iq.i_lsu_ready = 0;
    for (int k = 0; k < 4; k++) begin
      set_disp(0, 32'h0, 7'd0, 1, 32'h600 + k, 7'd0, 1, 32'h0, PW'(40 + k), RW'(k));
      step();
    end
    set_disp(0, 32'h0, 7'd0, 1, 32'h700, 7'd0, 1, 32'h0, 7'd50, 4'd5);
    iq.i_flush = 1;
    #1;
    tests++;
    if ({iq.o_count, iq.o_valid} !== {4'd4, 1'b1}) begin
      failed++;
      $display("[TB] FAIL flush_cycle: count=%0d valid=%b, required 4 1", iq.o_count, iq.o_valid);
    end
    step();
    idle();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({iq.o_count, iq.o_valid, iq.o_disp_ready} !== {4'd0, 1'b0, 1'b1}) begin
        failed++;
        $display("[TB] FAIL flush_after %0d: count=%0d valid=%b ready=%b, required 0 0 1",
                 k, iq.o_count, iq.o_valid, iq.o_disp_ready);
      end
      step();
    end
  endtask

  task automatic test_random();
    bit [PW-1:0] p1, p2;
    bit          r1, r2, mw;
    logic [3:0]    exp_cnt;
    logic [DW-1:0] exp_sd, got_sd;
    logic [144:0]  got, exp;
    for (int c = 0; c < 800; c++) begin
      idle();
      iq.i_lsu_ready = (((c / 64) % 2) == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      iq.i_flush = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 1) == 1) begin
        mw = $urandom_range(0, 1);
        p1 = PW'($urandom_range(0, 15));
        p2 = PW'($urandom_range(0, 15));
        r1 = (p1 == 0) || ($urandom_range(0, 2) != 0);
        r2 = (p2 == 0) || ($urandom_range(0, 2) != 0);
        set_disp(mw, $urandom, p1, r1, r1 ? $urandom : 32'h0, p2, r2, r2 ? $urandom : 32'h0,
                 PW'($urandom), RW'($urandom));
      end
      if ($urandom_range(0, 1) == 1) begin
        iq.i_cdb_valid = 1;
        iq.i_cdb_prd   = PW'($urandom_range(0, 15));
        iq.i_cdb_data  = $urandom;
      end
      step();
      exp_cnt = 4'(mq.size());
      if (mq.size() != 0) begin
        exp_sd = mq[0].mw ? mq[0].v2 : '0;
        exp = {m_valid(), exp_cnt, mq[0].v1, mq[0].imm, exp_sd, mq[0].mw, mq[0].prd, mq[0].rob};
      end else begin
        exp = {1'b0, exp_cnt, 140'd0};
      end
      got_sd = (mq.size() != 0 && !mq[0].mw) ? '0 : iq.o_store_data;
      got = {iq.o_valid, iq.o_count, iq.o_base_addr, iq.o_offset, got_sd, iq.o_memwrite, iq.o_prd, iq.o_rob_tag};
      tests++;
      if (got !== exp) begin
        failed++;
        $display("[TB] FAIL random cycle %0d: got %h, required %h", c, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_issue();
    test_store_wakeup();
    test_head_blocking();
    test_full_wrap();
    test_backpressure();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/lsu_issue_queue.md
Name: lsu_issue_queue

Overview:
- In-order memory-op queue directly upstream of the load/store unit; its issue port drives the LSU's operand, valid and metadata inputs.
- Holds dispatched loads/stores in program order and captures missing operands (rs1 base, rs2 store data) from the CDB.
- Issues only the head entry, once its operands are ready, with a valid/ready handshake against the LSU's backpressure output.

Parameters:
- DATA_WIDTH, 32, operand/immediate width
- ROB_WIDTH, 4, ROB tag width
- PREG_WIDTH, 7, physical register tag width
- DEPTH, 8, queue entries; power of two, >= 2

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i_flush  in  1  synchronous squash of all entries
- i_disp_valid  in  1  dispatch request
- o_disp_ready  out  1  queue can accept a dispatch
- i_disp_memwrite  in  1  1 = store, 0 = load
- i_disp_imm  in  DATA_WIDTH  address offset
- i_disp_prs1  in  PREG_WIDTH  base-register tag
- i_disp_rs1_rdy  in  1  base value valid at dispatch
- i_disp_rs1_val  in  DATA_WIDTH  base value
- i_disp_prs2  in  PREG_WIDTH  store-data tag
- i_disp_rs2_rdy  in  1  store data valid at dispatch
- i_disp_rs2_val  in  DATA_WIDTH  store data
- i_disp_prd  in  PREG_WIDTH  load destination tag
- i_disp_rob_tag  in  ROB_WIDTH  ROB tag
- i_cdb_valid  in  1  CDB broadcast valid
- i_cdb_prd  in  PREG_WIDTH  CDB tag
- i_cdb_data  in  DATA_WIDTH  CDB value
- o_valid  out  1  head entry issuable
- i_lsu_ready  in  1  LSU accepts this cycle
- o_base_addr  out  DATA_WIDTH  head rs1 value
- o_offset  out  DATA_WIDTH  head immediate
- o_store_data  out  DATA_WIDTH  head rs2 value
- o_memwrite  out  1  head is a store
- o_prd  out  PREG_WIDTH  head destination tag
- o_rob_tag  out  ROB_WIDTH  head ROB tag
- o_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Circular buffer: head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
- Reset (async): count = 0, pointers = 0, all entry fields = 0. Outputs after reset: o_valid = 0, o_disp_ready = 1, o_count = 0, all data/tag outputs = 0.
- o_disp_ready = (count < DEPTH). It depends only on the registered count; a pop in the same cycle does not make a full queue ready.
- Push when i_disp_valid && o_disp_ready. The entry is written at tail on the clock edge, and tail increments.
- Dispatch bypass: if an operand's rdy is 0 and, in the same cycle, i_cdb_valid is high with i_cdb_prd equal to its tag, the entry stores it as ready with i_cdb_data.
- Loads ignore rs2: rs2 is stored as ready.
- Wakeup: every valid entry with an unready operand whose tag equals i_cdb_prd captures i_cdb_data and sets that operand ready at the clock edge.
  - i_cdb_prd = 0 never wakes an operand; p0 sources arrive already ready.
- Issue is combinational from registered head state:
  - o_valid = (count != 0) && rs1_rdy[head] && (!memwrite[head] || rs2_rdy[head]).
  - Data/tag outputs always reflect the head entry; they are 0 when empty.
- Fire = o_valid && i_lsu_ready. On fire, head increments.
- A head operand woken on edge N makes o_valid high in the cycle after edge N (one cycle after the broadcast).
- Only the head may issue; younger ready entries wait (strict program order for memory).
- Push and pop in the same cycle leave count unchanged, and both pointers advance.
- Push into an empty queue: o_valid can be high no earlier than the cycle after the push edge.
- i_flush: at the next edge count = 0 and head = tail = 0. Flush overrides push, pop and wakeup in that cycle. o_valid is still evaluated normally during the flush cycle.
- Reset asserted mid-operation clears the queue immediately and asynchronously.

Optional Feature:
- Macro: LSU_IQ_STORE_COMMIT_EN.
- When defined:
  - Adds ports i_commit_valid (1) and i_commit_rob_tag (ROB_WIDTH).
  - A store at head raises o_valid only when, in addition to its operands being ready, i_commit_valid && i_commit_rob_tag == o_rob_tag, or a sticky per-entry commit bit is already set.
  - The sticky bit is set when a commit matches any valid store entry, and is cleared on dispatch.
  - Loads are unaffected.
- When undefined: the ports are absent, and stores issue as soon as their operands are ready.

Test Plan:
- Reset, then dispatch a load (rs1_rdy = 1, rs1_val = 0x100, imm = 0x8, prd = 5, rob = 3) with i_lsu_ready = 1 -> next cycle o_valid = 1, o_base_addr = 0x100, o_offset = 8, o_prd = 5, o_rob_tag = 3; the cycle after, o_count = 0.
- Dispatch a store with rs2 unready (prs2 = 9); broadcast CDB prd 9, data 0xDEAD two cycles later -> o_valid stays 0 until the cycle after the broadcast, then o_store_data = 0xDEAD and o_memwrite = 1.
- Head load blocked on rs1 (prs1 = 12) while a younger load is fully ready -> o_valid = 0 throughout; after CDB prd 12 both issue back-to-back in order.
- Fill DEPTH = 8 entries with i_lsu_ready = 0 -> o_disp_ready = 0 and o_count = 8; a 9th dispatch is dropped. Pop one, then dispatch -> tail wraps to 0 and ordering is preserved.
- Hold i_lsu_ready = 0 for 3 cycles with the head issuable -> o_valid and the outputs stay stable; the entry pops only on the cycle ready returns.
- With 4 entries queued, assert i_flush together with i_disp_valid -> next cycle o_count = 0, o_valid = 0, and the dispatched entry is not retained.
